// File: rtl/mc_mem_responder.sv
// rtl/mc_mem_responder.sv - word RAM responder with wait states and MemReady pulse
// Optional access checking (misaligned / out-of-range faults) under MC_MEM_ACCESS_CHECK_EN.
module mc_mem_responder #(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        MemReady,
    output logic        MemBusy,
    output logic        MemErr
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [31:0] lat_addr, lat_wdata;
    logic        lat_write;
    logic        accept;
    logic        enter_resp;
    logic [31:0] eff_addr, eff_wdata;
    logic        eff_write;
    logic [ADDR_W-1:0] idx;
    logic        fault;
    logic        ram_we;
    logic [31:0] mem [DEPTH];

    assign accept = (state == IDLE) && (MemRead || MemWrite);

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    cnt_nx = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES > 0) begin
                        state_nx = WAIT;
                    end else begin
                        state_nx   = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                cnt_nx = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nx   = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // With zero wait states the access happens on the accepting edge, before the latches fill.
    assign eff_addr  = (state == IDLE) ? Address   : lat_addr;
    assign eff_wdata = (state == IDLE) ? WriteData : lat_wdata;
    assign eff_write = (state == IDLE) ? MemWrite  : lat_write;
    assign idx       = eff_addr[ADDR_W+1:2];

    assign MemReady = (state == RESP);
    assign MemBusy  = (state != IDLE);

`ifdef MC_MEM_ACCESS_CHECK_EN
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);
    logic err_q;

    assign fault = (eff_addr[1:0] != 2'b00) || (eff_addr >= ADDR_LIMIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (enter_resp) begin
            err_q <= fault;
        end
    end

    assign MemErr = MemReady && err_q;
`else
    assign fault  = 1'b0;
    assign MemErr = 1'b0;
    wire unused_addr = &{1'b0, eff_addr[31:ADDR_W+2], eff_addr[1:0]};
`endif

    assign ram_we = enter_resp && eff_write && !fault;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            lat_write <= 1'b0;
            ReadData  <= 32'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                lat_addr  <= Address;
                lat_wdata <= WriteData;
                lat_write <= MemWrite;
            end
            if (enter_resp && !eff_write) begin
                ReadData <= fault ? 32'd0 : mem[idx];
            end
        end
    end

    // RAM contents survive reset; only the state machine gates the write strobe.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[idx] <= eff_wdata;
        end
    end

endmodule

// File: tb/tb_mc_mem_responder.sv
// tb/tb_mc_mem_responder.sv - directed bench for mc_mem_responder (WAIT_CYCLES=2 and 0 instances)
module tb_mc_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_rd, a_wr, b_rd, b_wr;
    logic [31:0] a_addr, a_wd, b_addr, b_wd;
    logic [31:0] a_rdata, b_rdata;
    logic        a_ready, a_busy, a_err;
    logic        b_ready, b_busy, b_err;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    mc_mem_responder #(.DEPTH(256), .ADDR_W(8), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .reset(reset), .MemRead(a_rd), .MemWrite(a_wr),
        .Address(a_addr), .WriteData(a_wd), .ReadData(a_rdata),
        .MemReady(a_ready), .MemBusy(a_busy), .MemErr(a_err)
    );

    mc_mem_responder #(.DEPTH(256), .ADDR_W(8), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset), .MemRead(b_rd), .MemWrite(b_wr),
        .Address(b_addr), .WriteData(b_wd), .ReadData(b_rdata),
        .MemReady(b_ready), .MemBusy(b_busy), .MemErr(b_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel == 0) begin
            a_rd = rd; a_wr = wr; a_addr = a; a_wd = d;
        end else begin
            b_rd = rd; b_wr = wr; b_addr = a; b_wd = d;
        end
    endtask

    function automatic logic get_ready(input int sel);
        return (sel == 0) ? a_ready : b_ready;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? a_busy : b_busy;
    endfunction

    function automatic logic get_err(input int sel);
        return (sel == 0) ? a_err : b_err;
    endfunction

    function automatic logic [31:0] get_rdata(input int sel);
        return (sel == 0) ? a_rdata : b_rdata;
    endfunction

    // One request from an IDLE negedge; operands are scrambled after accept.
    task automatic req(input int sel, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d, input int lat,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input logic busy_strobe, input string tag);
        int n;
        int bc;
        drive(sel, rd, wr, a, d);
        @(negedge clk);
        drive(sel, busy_strobe, 1'b0, busy_strobe ? 32'h0000_0008 : ~a, ~d);
        n  = 1;
        bc = 0;
        while (n <= 20) begin
            if (get_busy(sel)) bc++;
            if (get_ready(sel)) break;
            @(negedge clk);
            drive(sel, 1'b0, 1'b0, ~a, ~d);
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(lat));
        chk({tag, "_busy_cycles"}, 32'(bc), 32'(lat));
        chk({tag, "_rdata"}, get_rdata(sel), exp_rd);
        chk({tag, "_err"}, {31'd0, get_err(sel)}, {31'd0, exp_err});
        @(negedge clk);
        chk({tag, "_ready_pulse_end"}, {31'd0, get_ready(sel)}, 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("rst_a_rdata", a_rdata, 32'd0);
        chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
        chk("rst_a_busy",  {31'd0, a_busy},  32'd0);
        chk("rst_a_err",   {31'd0, a_err},   32'd0);
        chk("rst_b_busy",  {31'd0, b_busy},  32'd0);
        reset = 1'b1;

        // WAIT_CYCLES=2: write then read
        req(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3, 32'h0, 1'b0, 1'b0, "a_w10");
        req(0, 1'b1, 1'b0, 32'h10, 32'h0,        3, 32'hDEADBEEF, 1'b0, 1'b0, "a_r10");
        req(0, 1'b0, 1'b1, 32'h08, 32'h88888888, 3, 32'hDEADBEEF, 1'b0, 1'b0, "a_w08");
        req(0, 1'b1, 1'b0, 32'h08, 32'h0,        3, 32'h88888888, 1'b0, 1'b0, "a_r08");
        // Read strobe to 0x8 during WAIT must be ignored
        req(0, 1'b1, 1'b0, 32'h10, 32'h0,        3, 32'hDEADBEEF, 1'b0, 1'b1, "a_busy_r10");
        // Both strobes: write wins
        req(0, 1'b1, 1'b1, 32'h0C, 32'hA5A5A5A5, 3, 32'hDEADBEEF, 1'b0, 1'b0, "a_both_0c");
        req(0, 1'b1, 1'b0, 32'h0C, 32'h0,        3, 32'hA5A5A5A5, 1'b0, 1'b0, "a_r0c");

        // Reset in WAIT aborts the write
        req(0, 1'b0, 1'b1, 32'h20, 32'h00000000, 3, 32'hA5A5A5A5, 1'b0, 1'b0, "a_pre20");
        drive(0, 1'b0, 1'b1, 32'h20, 32'hFFFFFFFF);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("a_midw_busy", {31'd0, a_busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("a_midrst_rdata", a_rdata, 32'd0);
        chk("a_midrst_ready", {31'd0, a_ready}, 32'd0);
        chk("a_midrst_busy",  {31'd0, a_busy},  32'd0);
        chk("a_midrst_err",   {31'd0, a_err},   32'd0);
        @(negedge clk);
        reset = 1'b1;
        req(0, 1'b1, 1'b0, 32'h20, 32'h0, 3, 32'h00000000, 1'b0, 1'b0, "a_r20");
        req(0, 1'b1, 1'b0, 32'h0C, 32'h0, 3, 32'hA5A5A5A5, 1'b0, 1'b0, "a_r0c_after_rst");

        // WAIT_CYCLES=0 back-to-back; read strobe held through RESP
        drive(1, 1'b0, 1'b1, 32'h4, 32'h12345678);
        @(negedge clk);
        chk("b_w04_ready", {31'd0, b_ready}, 32'd1);
        chk("b_w04_rdata", b_rdata, 32'd0);
        drive(1, 1'b1, 1'b0, 32'h4, 32'h0);
        @(negedge clk);
        chk("b_resp_strobe_ignored_ready", {31'd0, b_ready}, 32'd0);
        chk("b_resp_strobe_ignored_busy",  {31'd0, b_busy},  32'd0);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("b_r04_ready", {31'd0, b_ready}, 32'd1);
        chk("b_r04_rdata", b_rdata, 32'h12345678);
        @(negedge clk);
        chk("b_r04_ready_end", {31'd0, b_ready}, 32'd0);

`ifdef MC_MEM_ACCESS_CHECK_EN
        req(1, 1'b0, 1'b1, 32'h000, 32'h33, 1, 32'h12345678, 1'b0, 1'b0, "b_w000");
        req(1, 1'b0, 1'b1, 32'h402, 32'h22, 1, 32'h12345678, 1'b1, 1'b0, "b_fault_w402");
        req(1, 1'b1, 1'b0, 32'h401, 32'h0,  1, 32'h00000000, 1'b1, 1'b0, "b_fault_r401");
        req(1, 1'b1, 1'b0, 32'h000, 32'h0,  1, 32'h00000033, 1'b0, 1'b0, "b_r000");
`else
        req(1, 1'b0, 1'b1, 32'h400, 32'h11, 1, 32'h12345678, 1'b0, 1'b0, "b_wrap_w400");
        req(1, 1'b1, 1'b0, 32'h000, 32'h0,  1, 32'h00000011, 1'b0, 1'b0, "b_wrap_r000");
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mc_mem_responder.md
Name: mc_mem_responder

Overview:
- Memory-side responder for the multi-cycle CPU. It answers the controller's MemRead/MemWrite strobes, which are address-muxed by IorD in the datapath.
- Holds a word-organised unified instruction/data RAM and inserts a configurable number of wait states.
- Signals completion with a one-cycle MemReady pulse. The controller stalls its fetch and memory-access states until that pulse arrives.

Parameters:
- DEPTH, 256, number of 32-bit words in the RAM (power of two).
- ADDR_W, 8, word-index width, equal to log2(DEPTH).
- WAIT_CYCLES, 2, wait states between accept and response (0..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- MemRead  input  1  read request strobe from the controller.
- MemWrite  input  1  write request strobe from the controller.
- Address  input  32  byte address (PC or ALUOut, selected by IorD).
- WriteData  input  32  store data (register B).
- ReadData  output  32  read result, valid while MemReady=1 and held afterwards.
- MemReady  output  1  one-cycle completion pulse for the accepted request.
- MemBusy  output  1  high from accept until MemReady, inclusive.
- MemErr  output  1  access fault flag, qualified by MemReady (see Optional Feature).

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state=IDLE, wait counter=0;
  - ReadData=0, MemReady=0, MemBusy=0, MemErr=0.
- RAM contents are not cleared by reset.
- Reset during WAIT or RESP aborts the request. A pending write is not committed.
- State machine IDLE / WAIT / RESP:
  - IDLE: when MemRead|MemWrite=1 on a rising edge, the block latches Address, WriteData and op.
    - op=write if MemWrite=1, else read. Write wins when both strobes are set.
    - Next state is WAIT if WAIT_CYCLES>0, else RESP. The counter loads WAIT_CYCLES.
  - WAIT: counter decrements once per cycle. When counter==1, next state is RESP.
  - RESP: lasts exactly one cycle, MemReady=1, then returns to IDLE.
- MemBusy=1 in WAIT and RESP.
- Strobes arriving while not in IDLE are ignored. There is no queue.
- Latency: MemReady rises WAIT_CYCLES+1 cycles after the accepting edge. With WAIT_CYCLES=0 it rises on the next cycle.
- Back-to-back: a strobe present during the RESP cycle is not accepted. It is accepted on the following IDLE edge, giving a minimum of one idle cycle between requests.
- Word index = latched Address[ADDR_W+1:2]. Address[1:0] and the upper bits are ignored, so out-of-range addresses wrap modulo DEPTH words.
- Read: ReadData is loaded with RAM[index] at the edge entering RESP and holds until the next read response or reset.
- Write:
  - RAM[index] <= latched WriteData at the edge entering RESP.
  - ReadData is unchanged.
  - MemReady pulses exactly as for a read.
- Latched operands are immune to Address/WriteData changes after accept.
- MemErr=0 whenever the optional feature is compiled out.

Optional Feature:
- Macro: MC_MEM_ACCESS_CHECK_EN.
- When defined, the latched request is a fault if either of these holds:
  - Address[1:0]!=0;
  - Address >= 4*DEPTH.
- On a fault:
  - the normal timing still applies;
  - in RESP, MemReady=1 and MemErr=1 for the same single cycle;
  - a faulting write does not modify RAM;
  - a faulting read loads ReadData=0.
- When not defined, there is no checking, MemErr is tied to 0 and addresses wrap as above.

Test Plan:
- Reset ordering: hold reset=0, then write 0x0000_0010 <- 0xDEADBEEF, then read 0x10 with WAIT_CYCLES=2 -> MemReady is high exactly 3 cycles after the read accept, ReadData=0xDEADBEEF, MemBusy high for 3 cycles.
- WAIT_CYCLES=0 back-to-back: write 0x4 <- 0x12345678, then read 0x4 -> each MemReady arrives 1 cycle after accept, read returns 0x12345678, and the strobe held through RESP is accepted only on the next cycle.
- Busy/simultaneous: assert MemRead with a new Address=0x8 during WAIT -> request ignored, data of the original address returned. Assert MemRead=MemWrite=1 at 0xC with 0xA5A5A5A5 -> treated as a write, subsequent read returns 0xA5A5A5A5.
- Reset mid-write: accept write 0x20 <- 0xFFFFFFFF, pull reset low in WAIT -> all outputs 0; a later read of 0x20 returns the prior value 0x00000000 (preloaded).
- Wrap (macro off): DEPTH=256, write 0x400 <- 0x11 -> read 0x0 returns 0x11, MemErr=0.
- Fault (macro on): write 0x402 <- 0x22 and read 0x401 -> MemErr=1 with MemReady, ReadData=0, RAM[0] unchanged.
